johnson_monitor: RTL and testbench

JOHNSON_MONITOR -- requirements
Module: johnson_monitor

---
 rtl/johnson_monitor_pkg.sv | 14 +
 rtl/johnson_monitor_if.sv | 32 +++
 rtl/johnson_decode.sv | 26 ++
 rtl/johnson_monitor.sv | 119 +++++++++++
 tb/tb_johnson_monitor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/johnson_monitor_pkg.sv
// Shared types and default constants for the Johnson-code sequence monitor.
package johnson_monitor_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/johnson_monitor_if.sv
// Sample/result bundle between a code source (master) and the monitor (slave).
// Handshake: a code is consumed on every rising clk edge where in_valid=1;
// there is no back-pressure, and idx_valid pulses one cycle later per sample.
interface johnson_monitor_if
  import johnson_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) ();
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] code;
  logic             clear_err;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             legal;
  logic             locked;
  logic             step_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, code, clear_err,
    input  idx, idx_valid, legal, locked, step_err, err_count
  );

  modport slave (
    input  in_valid, code, clear_err,
    output idx, idx_valid, legal, locked, step_err, err_count
  );

endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson-code legality check and position decode.
module johnson_decode #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  logic [WIDTH-1:0] norm;
  int               ones;

  // Folding the upper half onto the lower half leaves a legal code as a
  // run of ones anchored at bit 0, which is true iff norm & (norm+1) is zero.
  always_comb begin
    norm  = code[WIDTH-1] ? ~code : code;
    legal = ((norm & (norm + 1'b1)) == '0);
    ones  = $countones(code);
    idx   = '0;
    if (legal) begin
      idx = code[WIDTH-1] ? IDX_W'(2 * WIDTH - ones) : IDX_W'(ones);
    end
  end

endmodule

// File: rtl/johnson_monitor.sv
// Tracks a Johnson-coded counter, locks after LOCK_CNT clean steps, and
// counts sequence violations seen while locked.
module johnson_monitor
  import johnson_monitor_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               reset,
  johnson_monitor_if.slave   bus,
  output state_t             state_dbg
);

  localparam int IDX_W = $clog2(2 * WIDTH);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

  logic [IDX_W-1:0] dec_idx;
  logic             dec_legal;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (bus.code),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  state_t           state, state_nxt;
  logic [IDX_W-1:0] prev, prev_nxt, prev_inc;
  logic [RUN_W-1:0] run, run_nxt;
  logic             advance, hold, err_event;
  logic [IDX_W-1:0] idx_r;
  logic             legal_r, idx_valid_r, step_err_r;
  logic [ERR_W-1:0] err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      prev        <= '0;
      run         <= '0;
      idx_r       <= '0;
      legal_r     <= 1'b0;
      idx_valid_r <= 1'b0;
      step_err_r  <= 1'b0;
      err_r       <= '0;
    end else begin
      state       <= state_nxt;
      prev        <= prev_nxt;
      run         <= run_nxt;
      idx_valid_r <= bus.in_valid;
      step_err_r  <= err_event;
      if (bus.in_valid) begin
        idx_r   <= dec_idx;
        legal_r <= dec_legal;
      end
      // Clear takes priority over a coincident error.
      if (bus.clear_err) begin
        err_r <= '0;
      end else if (err_event && (err_r != '1)) begin
        err_r <= err_r + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    run_nxt   = run;
    err_event = 1'b0;
    prev_inc  = (prev == LAST_IDX) ? '0 : prev + 1'b1;
    advance   = dec_legal && (dec_idx == prev_inc);
    hold      = dec_legal && (dec_idx == prev);
    if (bus.in_valid) begin
      case (state)
        HUNT: begin
          if (dec_legal) begin
            state_nxt = TRACK;
            prev_nxt  = dec_idx;
            run_nxt   = '0;
          end
        end
        TRACK: begin
          if (!dec_legal) begin
            state_nxt = HUNT;
          end else if (advance) begin
            prev_nxt = dec_idx;
            run_nxt  = run + 1'b1;
            if (run_nxt == RUN_LOCK) state_nxt = LOCKED;
          end else if (!hold) begin
            prev_nxt = dec_idx;
            run_nxt  = '0;
          end
        end
        LOCKED: begin
          if (advance || hold) begin
            prev_nxt = dec_idx;
          end else begin
            err_event = 1'b1;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    bus.idx       = idx_r;
    bus.legal     = legal_r;
    bus.idx_valid = idx_valid_r;
    bus.step_err  = step_err_r;
    bus.err_count = err_r;
    bus.locked    = (state == LOCKED);
    state_dbg     = state;
  end

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed bench for johnson_monitor: vector table plus saturation and async-reset sequences.
module tb_johnson_monitor;
  import johnson_monitor_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     checks;
  int     errors;
  logic [7:0] exp_q[$];

  johnson_monitor_if #(.WIDTH(4), .ERR_W(8)) bus ();

  johnson_monitor #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic       clr;
    logic [2:0] idx;
    logic       iv;
    logic       legal;
    logic       locked;
    logic       serr;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t mk(input int v, input int c, input int clr, input int idx,
                              input int iv, input int lg, input int lk, input int se,
                              input int er);
    vec_t r;
    r.v = v[0]; r.code = c[3:0]; r.clr = clr[0]; r.idx = idx[2:0]; r.iv = iv[0];
    r.legal = lg[0]; r.locked = lk[0]; r.serr = se[0]; r.err = er[7:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [3:0] c, input logic clr);
    bus.in_valid  = v;
    bus.code      = c;
    bus.clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic relock();
    apply(1'b1, 4'h0, 1'b0);
    apply(1'b1, 4'h1, 1'b0);
    apply(1'b1, 4'h3, 1'b0);
    apply(1'b1, 4'h7, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.code = 4'h0;
    bus.clear_err = 1'b0;

    //      v  code clr idx iv lg lk se err
    tbl[0]  = mk(1, 'h0, 0, 0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 'h1, 0, 1, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 'h3, 0, 2, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 'h7, 0, 3, 1, 1, 1, 0, 0);
    tbl[4]  = mk(1, 'hF, 0, 4, 1, 1, 1, 0, 0);
    tbl[5]  = mk(1, 'hE, 0, 5, 1, 1, 1, 0, 0);
    tbl[6]  = mk(1, 'hC, 0, 6, 1, 1, 1, 0, 0);
    tbl[7]  = mk(1, 'h8, 0, 7, 1, 1, 1, 0, 0);
    tbl[8]  = mk(1, 'h0, 0, 0, 1, 1, 1, 0, 0);
    tbl[9]  = mk(1, 'h5, 0, 0, 1, 0, 0, 1, 1);
    tbl[10] = mk(1, 'h1, 0, 1, 1, 1, 0, 0, 1);
    tbl[11] = mk(0, 'h3, 0, 1, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 'h7, 0, 1, 0, 1, 0, 0, 1);
    tbl[13] = mk(1, 'h3, 0, 2, 1, 1, 0, 0, 1);
    tbl[14] = mk(1, 'h7, 0, 3, 1, 1, 0, 0, 1);
    tbl[15] = mk(0, 'hF, 0, 3, 0, 1, 0, 0, 1);
    tbl[16] = mk(1, 'hF, 0, 4, 1, 1, 1, 0, 1);
    tbl[17] = mk(1, 'hE, 0, 5, 1, 1, 1, 0, 1);
    tbl[18] = mk(1, 'hC, 0, 6, 1, 1, 1, 0, 1);
    tbl[19] = mk(1, 'h8, 0, 7, 1, 1, 1, 0, 1);
    tbl[20] = mk(1, 'h0, 0, 0, 1, 1, 1, 0, 1);
    tbl[21] = mk(1, 'h1, 0, 1, 1, 1, 1, 0, 1);
    tbl[22] = mk(1, 'h3, 0, 2, 1, 1, 1, 0, 1);
    tbl[23] = mk(1, 'h7, 0, 3, 1, 1, 1, 0, 1);
    tbl[24] = mk(1, 'h7, 0, 3, 1, 1, 1, 0, 1);
    tbl[25] = mk(1, 'hF, 0, 4, 1, 1, 1, 0, 1);
    tbl[26] = mk(1, 'hC, 0, 6, 1, 1, 0, 1, 2);
    tbl[27] = mk(1, 'h7, 0, 3, 1, 1, 0, 0, 2);
    tbl[28] = mk(1, 'h5, 0, 0, 1, 0, 0, 0, 2);
    tbl[29] = mk(1, 'h0, 1, 0, 1, 1, 0, 0, 0);
    tbl[30] = mk(1, 'h3, 0, 2, 1, 1, 0, 0, 0);
    tbl[31] = mk(1, 'h7, 0, 3, 1, 1, 0, 0, 0);
    tbl[32] = mk(1, 'h7, 0, 3, 1, 1, 0, 0, 0);
    tbl[33] = mk(1, 'hF, 0, 4, 1, 1, 0, 0, 0);
    tbl[34] = mk(1, 'hE, 0, 5, 1, 1, 1, 0, 0);
    tbl[35] = mk(1, 'hE, 0, 5, 1, 1, 1, 0, 0);

    // Reset state while reset is held.
    #12;
    check("rst_idx",    32'(bus.idx), 0);
    check("rst_legal",  32'(bus.legal), 0);
    check("rst_iv",     32'(bus.idx_valid), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_serr",   32'(bus.step_err), 0);
    check("rst_err",    32'(bus.err_count), 0);
    check("rst_state",  32'(state_dbg), 32'(HUNT));
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i].v, tbl[i].code, tbl[i].clr);
      check($sformatf("v%0d_idx", i),    32'(bus.idx),       32'(tbl[i].idx));
      check($sformatf("v%0d_iv", i),     32'(bus.idx_valid), 32'(tbl[i].iv));
      check($sformatf("v%0d_legal", i),  32'(bus.legal),     32'(tbl[i].legal));
      check($sformatf("v%0d_locked", i), 32'(bus.locked),    32'(tbl[i].locked));
      check($sformatf("v%0d_serr", i),   32'(bus.step_err),  32'(tbl[i].serr));
      check($sformatf("v%0d_err", i),    32'(bus.err_count), 32'(tbl[i].err));
    end

    // Drive err_count to 255 with 255 locked errors, each followed by a relock.
    for (int k = 0; k < 255; k++) begin
      apply(1'b1, 4'h5, 1'b0);
      relock();
    end
    exp_q.push_back(8'd255);
    check("sat_fill_err",    32'(bus.err_count), 32'(exp_q.pop_front()));
    check("sat_fill_locked", 32'(bus.locked), 1);
    apply(1'b1, 4'h5, 1'b0);
    exp_q.push_back(8'd255);
    check("sat_hold_err",  32'(bus.err_count), 32'(exp_q.pop_front()));
    check("sat_hold_serr", 32'(bus.step_err), 1);
    relock();
    apply(1'b1, 4'h5, 1'b1);
    exp_q.push_back(8'd0);
    check("clr_win_err",    32'(bus.err_count), 32'(exp_q.pop_front()));
    check("clr_win_serr",   32'(bus.step_err), 1);
    check("clr_win_locked", 32'(bus.locked), 0);

    // Asynchronous reset mid-cycle while locked with a nonzero error count.
    relock();
    apply(1'b1, 4'h5, 1'b0);
    exp_q.push_back(8'd1);
    check("pre_rst_err", 32'(bus.err_count), 32'(exp_q.pop_front()));
    relock();
    check("pre_rst_locked", 32'(bus.locked), 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_locked", 32'(bus.locked), 0);
    check("arst_err",    32'(bus.err_count), 0);
    check("arst_idx",    32'(bus.idx), 0);
    check("arst_legal",  32'(bus.legal), 0);
    check("arst_iv",     32'(bus.idx_valid), 0);
    check("arst_state",  32'(state_dbg), 32'(HUNT));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(1'b1, 4'h0, 1'b0);
    check("relock1_locked", 32'(bus.locked), 0);
    apply(1'b1, 4'h1, 1'b0);
    check("relock2_locked", 32'(bus.locked), 0);
    apply(1'b1, 4'h3, 1'b0);
    check("relock3_locked", 32'(bus.locked), 0);
    apply(1'b1, 4'h7, 1'b0);
    check("relock4_locked", 32'(bus.locked), 1);
    check("relock4_idx",    32'(bus.idx), 3);
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
